// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory requests and
// holds the IF/ID pipeline register feeding the decode/control unit.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        jmp,
  input  logic [25:0] jmp_addr,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  output logic [31:0] fetch_count
);

  // Architectural state
  logic [31:0] r_pc;
  logic [31:0] r_if_id_instr;
  logic [31:0] r_if_id_pc4;
  logic        r_if_id_valid;
  logic [31:0] r_fetch_count;

  // Next-state values
  logic [31:0] w_pc_d;
  logic [31:0] w_if_id_instr_d;
  logic [31:0] w_if_id_pc4_d;
  logic        w_if_id_valid_d;
  logic [31:0] w_fetch_count_d;

  // Redirect decode
  logic        w_redirect;
  logic [31:0] w_jump_target;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_pc_plus4;

  // The jump sits in ID, so its region bits come from the PC+4 held in IF/ID.
  assign w_redirect    = branch_taken | jmp;
  assign w_jump_target = {r_if_id_pc4[31:28], jmp_addr, 2'b00};
  // Branch resolves in EX and is therefore older than the jump in ID: it wins.
  assign w_redirect_pc = branch_taken ? branch_target : w_jump_target;
  assign w_pc_plus4    = r_pc + 32'd4;

  // Combinational outputs toward memory and the control unit
  assign imem_addr   = r_pc;
  assign imem_req    = rst_n & ~stall;
  assign if_id_instr = r_if_id_instr;
  assign if_id_pc4   = r_if_id_pc4;
  assign if_id_valid = r_if_id_valid;
  assign opcode      = r_if_id_instr[31:26];
  assign func        = r_if_id_instr[5:0];
  assign fetch_count = r_fetch_count;

  // Next-state selection: redirect beats stall, stall beats capture, else bubble
  always_comb begin
    w_pc_d          = r_pc;
    w_if_id_instr_d = r_if_id_instr;
    w_if_id_pc4_d   = r_if_id_pc4;
    w_if_id_valid_d = r_if_id_valid;
    w_fetch_count_d = r_fetch_count;

    if (w_redirect) begin
      // Any word returned this cycle belongs to the wrong path and is dropped.
      w_pc_d          = w_redirect_pc;
      w_if_id_instr_d = NOP_INSTR;
      w_if_id_pc4_d   = 32'd0;
      w_if_id_valid_d = 1'b0;
    end else if (stall) begin
      // Hold everything; a word returned now is re-requested at the same PC.
      w_pc_d = r_pc;
    end else if (imem_ready) begin
      w_pc_d          = w_pc_plus4;
      w_if_id_instr_d = imem_rdata;
      w_if_id_pc4_d   = w_pc_plus4;
      w_if_id_valid_d = 1'b1;
      w_fetch_count_d = r_fetch_count + 32'd1;
    end else begin
      w_if_id_instr_d = NOP_INSTR;
      w_if_id_pc4_d   = 32'd0;
      w_if_id_valid_d = 1'b0;
    end
  end

  // PC, IF/ID and fetch counter registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_pc4   <= 32'd0;
      r_if_id_valid <= 1'b0;
      r_fetch_count <= 32'd0;
    end else begin
      r_pc          <= w_pc_d;
      r_if_id_instr <= w_if_id_instr_d;
      r_if_id_pc4   <= w_if_id_pc4_d;
      r_if_id_valid <= w_if_id_valid_d;
      r_fetch_count <= w_fetch_count_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage against a behavioural pipeline model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        jmp = 1'b0;
  logic [25:0] jmp_addr = '0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready = 1'b0;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [31:0] fetch_count;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  logic        m_valid;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .jmp          (jmp),
    .jmp_addr     (jmp_addr),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_req     (imem_req),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .if_id_instr  (if_id_instr),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid),
    .opcode       (opcode),
    .func         (func),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2008_0005;
      32'h0000_0004: return 32'h0109_5020;
      32'h0000_0008: return 32'h012A_5822;
      default:       return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h5A3C};
    endcase
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_count = 32'h0;
  endtask

  // Pulse reset between edges and bring the model back to its reset state
  task automatic apply_reset();
    rst_n = 1'b0;
    #1 model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one cycle of inputs, clock it, and advance the model by the pipeline rules
  task automatic step(input logic st, input logic j, input logic [25:0] ja,
                      input logic bt, input logic [31:0] bta, input logic rdy);
    stall = st; jmp = j; jmp_addr = ja; branch_taken = bt; branch_target = bta;
    imem_ready = rdy;
    @(posedge clk);
    if (bt || j) begin
      m_pc    = bt ? bta : {m_pc4[31:28], ja, 2'b00};
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else if (st) begin
      m_pc = m_pc;
    end else if (rdy) begin
      m_instr = mem_word(m_pc);
      m_pc    = m_pc + 32'd4;
      m_pc4   = m_pc;
      m_valid = 1'b1;
      m_count = m_count + 32'd1;
    end else begin
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic fetch(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL reset_req: got %b expected 0", imem_req);
    end
    checks++;
    if (imem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_addr: got %h expected 00000000", imem_addr);
    end
    checks++;
    if ({if_id_instr, if_id_pc4, if_id_valid} !== 65'h0) begin
      errors++;
      $display("FAIL reset_ifid: got %h/%h/%b expected 0/0/0", if_id_instr, if_id_pc4,
               if_id_valid);
    end
    checks++;
    if (fetch_count !== 32'h0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", fetch_count);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc4;
    for (int i = 0; i < 3; i++) begin
      fetch(1);
      exp_pc4 = 32'd4 * (i + 1);
      checks++;
      if (if_id_pc4 !== exp_pc4 || if_id_valid !== 1'b1) begin
        errors++;
        $display("FAIL seq_pc4[%0d]: got %h/%b expected %h/1", i, if_id_pc4, if_id_valid,
                 exp_pc4);
      end
      checks++;
      if (if_id_instr !== m_instr) begin
        errors++; $display("FAIL seq_instr[%0d]: got %h expected %h", i, if_id_instr, m_instr);
      end
      if (i == 0) begin
        checks++;
        if (opcode !== 6'h08) begin
          errors++; $display("FAIL seq_opcode0: got %h expected 08", opcode);
        end
      end else if (i == 1) begin
        checks++;
        if (opcode !== 6'h00 || func !== 6'h20) begin
          errors++; $display("FAIL seq_op_func1: got %h/%h expected 00/20", opcode, func);
        end
      end
    end
    checks++;
    if (fetch_count !== 32'd3) begin
      errors++; $display("FAIL seq_count: got %0d expected 3", fetch_count);
    end
  endtask

  task automatic test_stall();
    logic [31:0] pc0, instr0, cnt0;
    pc0 = m_pc; instr0 = m_instr; cnt0 = m_count;
    stall = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL stall_req: got %b expected 0", imem_req);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 26'h0, 1'b0, 32'h0, 1'b1);
      checks++;
      if (imem_addr !== pc0 || if_id_instr !== instr0 || fetch_count !== cnt0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got %h/%h/%0d expected %h/%h/%0d", i, imem_addr,
                 if_id_instr, fetch_count, pc0, instr0, cnt0);
      end
    end
    fetch(1);
    checks++;
    if (if_id_instr !== mem_word(pc0) || if_id_pc4 !== pc0 + 32'd4) begin
      errors++;
      $display("FAIL stall_resume: got %h/%h expected %h/%h", if_id_instr, if_id_pc4,
               mem_word(pc0), pc0 + 32'd4);
    end
  endtask

  task automatic test_not_ready();
    logic [31:0] pc0;
    pc0 = m_pc;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
      checks++;
      if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || imem_addr !== pc0) begin
        errors++;
        $display("FAIL notready_bubble[%0d]: got %b/%h/%h expected 0/0/%h", i, if_id_valid,
                 if_id_instr, imem_addr, pc0);
      end
    end
    fetch(1);
    checks++;
    if (if_id_instr !== mem_word(pc0) || if_id_valid !== 1'b1) begin
      errors++;
      $display("FAIL notready_capture: got %h/%b expected %h/1", if_id_instr, if_id_valid,
               mem_word(pc0));
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    fetch(4);
    step(1'b0, 1'b1, 26'h000_0040, 1'b0, 32'h0, 1'b1);
    checks++;
    if (imem_addr !== 32'h0000_0100 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
      errors++;
      $display("FAIL jump: got %h/%b/%h expected 00000100/0/0", imem_addr, if_id_valid,
               if_id_instr);
    end
    checks++;
    if (fetch_count !== 32'd4) begin
      errors++; $display("FAIL jump_count: got %0d expected 4", fetch_count);
    end
    fetch(1);
    checks++;
    if (if_id_instr !== mem_word(32'h100) || if_id_pc4 !== 32'h104) begin
      errors++;
      $display("FAIL jump_target_fetch: got %h/%h expected %h/00000104", if_id_instr,
               if_id_pc4, mem_word(32'h100));
    end
    apply_reset();
    fetch(4);
    step(1'b0, 1'b1, 26'h000_0040, 1'b1, 32'h0000_0200, 1'b1);
    checks++;
    if (imem_addr !== 32'h0000_0200 || if_id_valid !== 1'b0) begin
      errors++;
      $display("FAIL branch_over_jump: got %h/%b expected 00000200/0", imem_addr, if_id_valid);
    end
  endtask

  task automatic test_redirect_stall();
    logic [31:0] cnt0;
    cnt0 = m_count;
    step(1'b1, 1'b0, 26'h0, 1'b1, 32'h0000_0300, 1'b1);
    checks++;
    if (imem_addr !== 32'h0000_0300 || if_id_valid !== 1'b0 || if_id_pc4 !== 32'h0 ||
        fetch_count !== cnt0) begin
      errors++;
      $display("FAIL redirect_stall: got %h/%b/%h/%0d expected 00000300/0/0/%0d", imem_addr,
               if_id_valid, if_id_pc4, fetch_count, cnt0);
    end
  endtask

  task automatic test_async_reset();
    fetch(3);
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_addr !== 32'h0 || imem_req !== 1'b0 || if_id_valid !== 1'b0 ||
        if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0 || fetch_count !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: got %h/%b/%b/%h/%h/%0d expected 0/0/0/0/0/0", imem_addr,
               imem_req, if_id_valid, if_id_instr, if_id_pc4, fetch_count);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    fetch(1);
    checks++;
    if (if_id_pc4 !== 32'h0 || imem_addr !== 32'h0 || if_id_instr !== mem_word(32'hFFFF_FFFC))
    begin
      errors++;
      $display("FAIL wrap: got %h/%h/%h expected 0/0/%h", if_id_pc4, imem_addr, if_id_instr,
               mem_word(32'hFFFF_FFFC));
    end
  endtask

  task automatic test_random();
    logic st, j, bt, rdy;
    logic [25:0] ja;
    logic [31:0] bta;
    for (int i = 0; i < 400; i++) begin
      st  = ($urandom_range(0, 3) == 0);
      j   = ($urandom_range(0, 11) == 0);
      bt  = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      ja  = 26'($urandom);
      bta = $urandom;
      step(st, j, ja, bt, bta, rdy);
      checks++;
      if (imem_addr !== m_pc || if_id_instr !== m_instr || if_id_pc4 !== m_pc4 ||
          if_id_valid !== m_valid || fetch_count !== m_count || imem_req !== ~st ||
          opcode !== m_instr[31:26] || func !== m_instr[5:0]) begin
        errors++;
        $display("FAIL random[%0d]: got pc=%h ins=%h pc4=%h v=%b cnt=%0d req=%b expected pc=%h ins=%h pc4=%h v=%b cnt=%0d req=%b",
                 i, imem_addr, if_id_instr, if_id_pc4, if_id_valid, fetch_count, imem_req,
                 m_pc, m_instr, m_pc4, m_valid, m_count, ~st);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_not_ready();
    test_redirect();
    test_redirect_stall();
    test_async_reset();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
